boiler_stack_renderer: RTL and testbench



---
 rtl/boiler_stack_renderer.sv | 184 ++++++++++++++++++
 tb/tb_boiler_stack_renderer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boiler_stack_renderer.sv
// Boiler sprite with an animated stack of colour layers.
// Push/pop commands fill or drain one band row by row on frame ticks.
module boiler_stack_renderer #(
    parameter int LAYERS      = 4,
    parameter int LAYER_H     = 5,
    parameter int CAP_H       = 4,
    parameter int STEP_FRAMES = 2,
    localparam int LW         = $clog2(LAYERS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic [6:0]    X,
    input  logic [5:0]    Y,
    input  logic [6:0]    leftX,
    input  logic [5:0]    topY,
    input  logic [15:0]   BACKGROUND,
    input  logic          selected,
    input  logic          cmd_valid,
    input  logic          cmd_push,
    input  logic [2:0]    cmd_colour,
    output logic          cmd_ready,
    output logic          done,
    output logic [2:0]    done_colour,
    output logic          err,
    output logic [LW-1:0] level,
    output logic [15:0]   oled_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam int FW       = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int BODY_END = CAP_H + LAYERS * LAYER_H;

    localparam logic [15:0] WHITE = 16'hFFFF;
    localparam logic [15:0] RED   = 16'hF800;
    localparam logic [15:0] BROWN = 16'h61E0;
    localparam logic [15:0] BLACK = 16'h0000;

    function automatic logic [15:0] slot_rgb(input logic [2:0] code);
        case (code)
            3'b000:  slot_rgb = 16'hFFFF;
            3'b001:  slot_rgb = 16'hCB92;
            3'b010:  slot_rgb = 16'hA777;
            3'b011:  slot_rgb = 16'hED6C;
            3'b100:  slot_rgb = 16'h0016;
            3'b101:  slot_rgb = 16'h06BF;
            3'b110:  slot_rgb = 16'hA534;
            default: slot_rgb = RED;
        endcase
    endfunction

    logic [1:0]    state;
    logic [2:0]    slots [16];
    logic [3:0]    anim_rows;
    logic [FW-1:0] fcnt;
    logic [3:0]    lvl4;
    logic [3:0]    top4;
    logic          accept;
    logic          push_ok;
    logic          pop_ok;
    logic          step;
    logic          last;

    assign lvl4      = 4'(level);
    assign top4      = lvl4 - 4'd1;
    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign push_ok   = cmd_push && (level < LW'(LAYERS)) && (cmd_colour != 3'b111);
    assign pop_ok    = !cmd_push && (level != '0);
    assign step      = frame_tick && (fcnt == FW'(STEP_FRAMES - 1));
    assign last      = step && (anim_rows == 4'(LAYER_H - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            level       <= '0;
            anim_rows   <= '0;
            fcnt        <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            done_colour <= 3'b000;
            for (int i = 0; i < 16; i++) slots[i] <= 3'b000;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (push_ok) begin
                            slots[lvl4] <= cmd_colour;
                            anim_rows   <= '0;
                            fcnt        <= '0;
                            state       <= S_FILL;
                        end else if (pop_ok) begin
                            anim_rows <= '0;
                            fcnt      <= '0;
                            state     <= S_DRAIN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (step) begin
                        fcnt      <= '0;
                        anim_rows <= anim_rows + 4'd1;
                    end else if (frame_tick) begin
                        fcnt <= fcnt + FW'(1);
                    end
                    // Final row step commits the level change and releases the FSM.
                    if (last) begin
                        state     <= S_IDLE;
                        done      <= 1'b1;
                        anim_rows <= '0;
                        if (state == S_FILL) begin
                            level       <= level + LW'(1);
                            done_colour <= slots[lvl4];
                        end else begin
                            level       <= level - LW'(1);
                            done_colour <= slots[top4];
                        end
                    end
                end
            endcase
        end
    end

    logic [7:0]  r;
    logic [7:0]  c;
    logic [7:0]  b;
    logic [7:0]  band;
    logic [7:0]  k;
    logic [7:0]  s;
    logic [7:0]  lvl8;
    logic [7:0]  rows8;
    logic [15:0] sc;
    logic [15:0] band_col;
    logic [15:0] pix;

    assign r     = {2'b00, Y} - {2'b00, topY};
    assign c     = {1'b0, X} - {1'b0, leftX};
    assign lvl8  = 8'(level);
    assign rows8 = {4'b0000, anim_rows};

    always_comb begin
        b    = r - 8'(CAP_H);
        band = b / 8'(LAYER_H);
        k    = b % 8'(LAYER_H);
        s    = 8'(LAYERS - 1) - band;
        sc   = slot_rgb(slots[s[3:0]]);
        // The animated band is checked before committed slots so a draining top layer empties.
        if (state == S_DRAIN && s == lvl8 - 8'd1)
            band_col = (k >= rows8) ? sc : WHITE;
        else if (s < lvl8)
            band_col = sc;
        else if (state == S_FILL && s == lvl8)
            band_col = (k >= 8'(LAYER_H) - rows8) ? sc : WHITE;
        else
            band_col = WHITE;
    end

    always_comb begin
        pix = BACKGROUND;
        if (!(Y < topY || X < leftX)) begin
            if (r < 8'(CAP_H)) begin
                if (c >= 8'd5 && c <= 8'd12) pix = selected ? RED : BROWN;
            end else if (r < 8'(BODY_END)) begin
                if (c == 8'd0 || c == 8'd17) pix = BLACK;
                else if (c <= 8'd16)         pix = band_col;
            end else if (r == 8'(BODY_END) && c <= 8'd17) begin
                pix = BLACK;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) oled_data <= 16'h0000;
        else       oled_data <= pix;
    end

endmodule

// File: tb/tb_boiler_stack_renderer.sv
// Directed + randomized bench for boiler_stack_renderer.
// Expected pixels and command results come from a queue-based stack model.
module tb_boiler_stack_renderer;

    localparam int LAYERS  = 4;
    localparam int LAYER_H = 5;
    localparam int CAP_H   = 4;
    localparam int STEP    = 2;
    localparam int LW      = $clog2(LAYERS + 1);
    localparam int NTICKS  = LAYER_H * STEP;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_tick;
    logic [6:0]    X;
    logic [5:0]    Y;
    logic [6:0]    leftX;
    logic [5:0]    topY;
    logic [15:0]   BACKGROUND;
    logic          selected;
    logic          cmd_valid;
    logic          cmd_push;
    logic [2:0]    cmd_colour;
    logic          cmd_ready;
    logic          done;
    logic [2:0]    done_colour;
    logic          err;
    logic [LW-1:0] level;
    logic [15:0]   oled_data;

    boiler_stack_renderer #(
        .LAYERS(LAYERS), .LAYER_H(LAYER_H), .CAP_H(CAP_H), .STEP_FRAMES(STEP)
    ) dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick),
        .X(X), .Y(Y), .leftX(leftX), .topY(topY),
        .BACKGROUND(BACKGROUND), .selected(selected),
        .cmd_valid(cmd_valid), .cmd_push(cmd_push), .cmd_colour(cmd_colour),
        .cmd_ready(cmd_ready), .done(done), .done_colour(done_colour),
        .err(err), .level(level), .oled_data(oled_data)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: committed stack bottom..top, current animation and its tick count.
    int q[$];
    int mode  = 0;
    int pend  = 0;
    int ticks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rgb(input int code);
        case (code)
            0: return 'hFFFF;
            1: return 'hCB92;
            2: return 'hA777;
            3: return 'hED6C;
            4: return 'h0016;
            5: return 'h06BF;
            6: return 'hA534;
            default: return 'hF800;
        endcase
    endfunction

    function automatic int ref_pix(input int x, input int y, input bit sel);
        int r, cc, lay, s, k, lvl, rows, body_end;
        if (y < int'(topY) || x < int'(leftX)) return int'(BACKGROUND);
        r  = y - int'(topY);
        cc = x - int'(leftX);
        body_end = CAP_H + LAYERS * LAYER_H;
        if (r < CAP_H)
            return (cc >= 5 && cc <= 12) ? (sel ? 'hF800 : 'h61E0) : int'(BACKGROUND);
        if (r == body_end)
            return (cc <= 17) ? 0 : int'(BACKGROUND);
        if (r > body_end) return int'(BACKGROUND);
        if (cc == 0 || cc == 17) return 0;
        if (cc > 17) return int'(BACKGROUND);
        lay  = (r - CAP_H) / LAYER_H;
        k    = (r - CAP_H) % LAYER_H;
        s    = LAYERS - 1 - lay;
        lvl  = q.size();
        rows = ticks / STEP;
        if (mode == 2 && s == lvl - 1) return (k >= rows) ? rgb(q[s]) : 'hFFFF;
        if (s < lvl) return rgb(q[s]);
        if (mode == 1 && s == lvl) return (k >= LAYER_H - rows) ? rgb(pend) : 'hFFFF;
        return 'hFFFF;
    endfunction

    task automatic pix(input string tag, input int x, input int y, input bit sel);
        @(negedge clk);
        X = x[6:0];
        Y = y[5:0];
        selected = sel;
        @(posedge clk);
        #1;
        chk(tag, oled_data, ref_pix(x, y, sel));
    endtask

    task automatic cmd(input bit push, input int code);
        int lvl;
        bit ok;
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_push   = push;
        cmd_colour = code[2:0];
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lvl = q.size();
        ok  = push ? (lvl < LAYERS && code != 7) : (lvl > 0);
        if (ok) begin
            mode  = push ? 1 : 2;
            pend  = code;
            ticks = 0;
            chk("ready_drop", cmd_ready, 0);
            chk("no_err_accept", err, 0);
        end else begin
            chk("err_pulse", err, 1);
            chk("rej_ready", cmd_ready, 1);
            chk("rej_level", level, lvl);
            @(posedge clk);
            #1;
            chk("err_once", err, 0);
            chk("rej_level_hold", level, lvl);
        end
    endtask

    task automatic tick();
        bit fin;
        int code;
        fin  = 0;
        code = 0;
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (mode != 0) begin
            ticks++;
            if (ticks == NTICKS) begin
                fin = 1;
                if (mode == 1) begin
                    code = pend;
                    q.push_back(pend);
                end else begin
                    code = q.pop_back();
                end
                mode  = 0;
                ticks = 0;
            end
        end
        chk("done", done, fin);
        chk("no_err_tick", err, 0);
        if (fin) begin
            chk("done_colour", done_colour, code);
            chk("done_level", level, q.size());
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        if (fin) begin
            chk("ready_after_done", cmd_ready, 1);
            chk("done_colour_held", done_colour, code);
        end
    endtask

    task automatic run_cmd(input bit push, input int code);
        int at;
        cmd(push, code);
        if (mode != 0) begin
            at = $urandom_range(1, NTICKS - 1);
            for (int t = 1; t <= NTICKS; t++) begin
                tick();
                if (t == at)
                    pix("anim_pix", int'(leftX) + $urandom_range(1, 16),
                        int'(topY) + CAP_H + $urandom_range(0, LAYERS * LAYER_H - 1), 0);
            end
        end
    endtask

    initial begin
        int x, y;
        reset      = 1'b1;
        frame_tick = 1'b0;
        cmd_valid  = 1'b0;
        cmd_push   = 1'b0;
        cmd_colour = 3'b000;
        X          = '0;
        Y          = '0;
        selected   = 1'b0;
        leftX      = 7'd10;
        topY       = 6'd5;
        BACKGROUND = 16'($urandom);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_level", level, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_oled", oled_data, 16'h0000);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_done_colour", done_colour, 0);
        @(negedge clk);
        reset = 1'b0;

        pix("body_white_model", int'(leftX) + 5, int'(topY) + 6, 0);
        chk("body_white", oled_data, 16'hFFFF);

        // Push ORANGE and inspect the bottom band half way through.
        cmd(1, 3);
        repeat (2 * STEP) tick();
        for (int k = 0; k < LAYER_H; k++)
            pix("fill_band", int'(leftX) + 5,
                int'(topY) + CAP_H + (LAYERS - 1) * LAYER_H + k, 0);
        chk("fill_row4", oled_data, 16'hED6C);
        repeat (NTICKS - 2 * STEP) tick();
        chk("push_level1", level, 1);

        run_cmd(1, $urandom_range(0, 6));
        run_cmd(1, $urandom_range(0, 6));
        run_cmd(1, 5);
        chk("full_level", level, LAYERS);
        cmd(1, $urandom_range(0, 6));

        // Drain the LIGHTBLUE top layer.
        cmd(0, 0);
        repeat (2 * STEP) tick();
        for (int k = 0; k < LAYER_H; k++)
            pix("drain_band", int'(leftX) + 8, int'(topY) + CAP_H + k, 0);
        chk("drain_row4", oled_data, 16'h06BF);
        repeat (NTICKS - 2 * STEP) tick();
        chk("pop_level3", level, 3);
        chk("pop_colour", done_colour, 5);

        for (int i = 0; i < 24; i++) begin
            x = int'(leftX) - 2 + $urandom_range(0, 22);
            y = int'(topY) - 2 + $urandom_range(0, CAP_H + LAYERS * LAYER_H + 3);
            pix("sweep", x, y, 1'($urandom));
        end

        // Reset in the middle of a drain aborts without a done pulse.
        cmd(0, 0);
        repeat (3) tick();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        mode  = 0;
        ticks = 0;
        @(posedge clk);
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_done_colour", done_colour, 0);
        repeat (NTICKS) tick();

        cmd(0, 0);
        cmd(1, 7);
        run_cmd(1, $urandom_range(0, 6));

        pix("cap_red", int'(leftX) + 6, int'(topY) + 1, 1);
        chk("cap_red_lit", oled_data, 16'hF800);
        pix("cap_brown", int'(leftX) + 6, int'(topY) + 1, 0);
        chk("cap_brown_lit", oled_data, 16'h61E0);
        pix("left_bg", int'(leftX) - 1, int'(topY) + 8, 1);
        chk("left_bg_lit", oled_data, BACKGROUND);
        pix("base_black", int'(leftX) + 17, int'(topY) + CAP_H + LAYERS * LAYER_H, 0);

        // Sprite hanging over the bottom-right corner must not wrap.
        leftX = 7'd115;
        topY  = 6'd40;
        pix("edge_corner", 127, 63, 0);
        for (int i = 0; i < 10; i++)
            pix("edge_rand", $urandom_range(108, 127), $urandom_range(34, 63), 1'($urandom));
        leftX = 7'd127;
        topY  = 6'd63;
        pix("wrap_corner", 127, 63, 1);
        pix("wrap_origin", 0, 0, 1);
        chk("wrap_origin_bg", oled_data, BACKGROUND);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
